// File: rtl/prm_edge_query_seq.sv
// rtl/prm_edge_query_seq.sv - edge-query sequencer: drives obstacle checker, packs edge masks LSB-first
// Each accepted code is held on chk_code for one settle cycle, then its mask bit is packed into res_word.
module prm_edge_query_seq #(
   parameter int CODE_W = 15,
   parameter int PACK_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [CODE_W-1:0] req_code,
   input  logic              req_last,
   output logic [CODE_W-1:0] chk_code,
   input  logic              chk_mask,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [PACK_W-1:0] res_word,
   output logic [5:0]        res_count,
   output logic              res_last,
   output logic [CNT_W-1:0]  blocked_cnt,
   output logic              busy
);

   localparam int IDX_W  = $clog2(PACK_W);
   localparam int FILL_W = IDX_W + 1;

   typedef enum logic [1:0] {IDLE, EVAL, EMIT} state_t;

   state_t            state;
   state_t            state_nxt;
   logic [FILL_W-1:0] fill;
   logic [FILL_W-1:0] fill_inc;
   logic              last_q;
   logic              close_word;

   assign fill_inc   = fill + FILL_W'(1);
   // A word closes when it fills up or the batch ends, whichever comes first.
   assign close_word = (fill_inc == FILL_W'(PACK_W)) || last_q;
   assign busy       = (state != IDLE) || (fill != '0);

   always_ff @(posedge CLK) begin
      if (RST) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      req_ready = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_nxt = EVAL;
         end
         EVAL:    state_nxt = close_word ? EMIT : IDLE;
         EMIT:    if (res_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         chk_code    <= '0;
         last_q      <= 1'b0;
         fill        <= '0;
         res_valid   <= 1'b0;
         res_word    <= '0;
         res_count   <= '0;
         res_last    <= 1'b0;
         blocked_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  chk_code <= req_code;
                  last_q   <= req_last;
               end
            end
            EVAL: begin
               res_word[fill[IDX_W-1:0]] <= chk_mask;
               fill                      <= fill_inc;
               if (chk_mask && (blocked_cnt != '1))
                  blocked_cnt <= blocked_cnt + CNT_W'(1);
               if (close_word) begin
                  res_count <= 6'(fill_inc);
                  res_last  <= last_q;
                  res_valid <= 1'b1;
               end
            end
            EMIT: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  res_word  <= '0;
                  fill      <= '0;
                  res_last  <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_prm_edge_query_seq.sv
// tb/tb_prm_edge_query_seq.sv - directed bench for prm_edge_query_seq with a parity checker stub
module tb_prm_edge_query_seq;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready, req_ready_s;
   logic [14:0] req_code = '0;
   logic        req_last = 1'b0;
   logic [14:0] chk_code, chk_code_s;
   logic        chk_mask, chk_mask_s;
   logic        res_valid, res_valid_s;
   logic        res_ready = 1'b0;
   logic [31:0] res_word, res_word_s;
   logic [5:0]  res_count, res_count_s;
   logic        res_last, res_last_s;
   logic [15:0] blocked_cnt;
   logic [3:0]  blocked_cnt_s;
   logic        busy, busy_s;

   int n_checks = 0;
   int n_fail   = 0;
   logic rand_ready  = 1'b0;
   logic ready_force = 1'b0;

   logic [31:0] q_word[$];
   logic [5:0]  q_cnt[$];
   logic        q_last[$];

   assign chk_mask   = ^chk_code;
   assign chk_mask_s = ^chk_code_s;

   prm_edge_query_seq dut (
      .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_ready(req_ready),
      .req_code(req_code), .req_last(req_last), .chk_code(chk_code), .chk_mask(chk_mask),
      .res_valid(res_valid), .res_ready(res_ready), .res_word(res_word), .res_count(res_count),
      .res_last(res_last), .blocked_cnt(blocked_cnt), .busy(busy)
   );

   prm_edge_query_seq #(.CNT_W(4)) dut_sat (
      .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_ready(req_ready_s),
      .req_code(req_code), .req_last(req_last), .chk_code(chk_code_s), .chk_mask(chk_mask_s),
      .res_valid(res_valid_s), .res_ready(res_ready), .res_word(res_word_s), .res_count(res_count_s),
      .res_last(res_last_s), .blocked_cnt(blocked_cnt_s), .busy(busy_s)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) begin
      #1;
      res_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_force;
   end

   always @(negedge CLK) begin
      if (!RST && res_valid && res_ready) begin
         q_word.push_back(res_word);
         q_cnt.push_back(res_count);
         q_last.push_back(res_last);
      end
   end

   task automatic clear_q();
      q_word.delete();
      q_cnt.delete();
      q_last.delete();
   endtask

   task automatic do_reset(input int cycles);
      @(negedge CLK);
      RST = 1'b1;
      repeat (cycles) @(negedge CLK);
      RST = 1'b0;
   endtask

   task automatic send(input logic [14:0] code, input logic last);
      int n = 0;
      @(negedge CLK);
      req_valid = 1'b1;
      req_code  = code;
      req_last  = last;
      while (!req_ready && n < 1000) begin
         @(negedge CLK);
         n++;
      end
      if (!req_ready) begin
         n_checks++; n_fail++;
         $display("FAIL send_timeout: req_ready=%0b required 1", req_ready);
      end
      @(posedge CLK);
      #1 req_valid = 1'b0;
      req_last = 1'b0;
   endtask

   task automatic wait_words(input int n);
      int t = 0;
      while (q_word.size() < n && t < 5000) begin
         @(negedge CLK);
         t++;
      end
      if (q_word.size() < n) begin
         n_checks++; n_fail++;
         $display("FAIL wait_words: got %0d words required %0d", q_word.size(), n);
      end
      repeat (4) @(negedge CLK);
   endtask

   task automatic test_reset();
      do_reset(3);
      n_checks++;
      if (res_valid !== 1'b0 || blocked_cnt !== 16'd0 || req_ready !== 1'b1 || busy !== 1'b0 ||
          res_word !== 32'd0 || res_count !== 6'd0 || res_last !== 1'b0 || chk_code !== 15'd0) begin
         n_fail++;
         $display("FAIL reset_state: valid=%0b cnt=%0d ready=%0b busy=%0b word=%h count=%0d last=%0b chk=%h required 0,0,1,0,0,0,0,0",
                  res_valid, blocked_cnt, req_ready, busy, res_word, res_count, res_last, chk_code);
      end
   endtask

   task automatic test_reset_mid_emit();
      int t = 0;
      ready_force = 1'b0;
      repeat (2) @(negedge CLK);
      clear_q();
      send(15'd1, 1'b1);
      while (!res_valid && t < 20) begin @(negedge CLK); t++; end
      n_checks++;
      if (res_valid !== 1'b1 || blocked_cnt !== 16'd1) begin
         n_fail++;
         $display("FAIL pre_reset_emit: valid=%0b cnt=%0d required 1,1", res_valid, blocked_cnt);
      end
      do_reset(3);
      n_checks++;
      if (res_valid !== 1'b0 || blocked_cnt !== 16'd0 || req_ready !== 1'b1 || busy !== 1'b0 || res_word !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_mid_emit: valid=%0b cnt=%0d ready=%0b busy=%0b word=%h required 0,0,1,0,0",
                  res_valid, blocked_cnt, req_ready, busy, res_word);
      end
      ready_force = 1'b1;
      repeat (3) @(negedge CLK);
      n_checks++;
      if (q_word.size() != 0) begin
         n_fail++;
         $display("FAIL reset_drop_word: %0d words emitted required 0", q_word.size());
      end
   endtask

   task automatic test_full_word(input logic last_on_end, input logic [15:0] exp_blocked);
      clear_q();
      for (int i = 0; i < 32; i++) send(15'(i), last_on_end && (i == 31));
      wait_words(1);
      n_checks++;
      if (q_word.size() != 1) begin
         n_fail++;
         $display("FAIL full_word_count: %0d words required 1", q_word.size());
      end else begin
         n_checks++;
         if (q_word[0] !== 32'h96696996 || q_cnt[0] !== 6'd32 || q_last[0] !== last_on_end) begin
            n_fail++;
            $display("FAIL full_word: word=%h count=%0d last=%0b required 96696996,32,%0b",
                     q_word[0], q_cnt[0], q_last[0], last_on_end);
         end
      end
      n_checks++;
      if (blocked_cnt !== exp_blocked) begin
         n_fail++;
         $display("FAIL full_word_blocked: %0d required %0d", blocked_cnt, exp_blocked);
      end
   endtask

   task automatic test_first_edge_last();
      clear_q();
      send(15'd7, 1'b1);
      wait_words(1);
      n_checks++;
      if (q_word.size() != 1 || q_word[0] !== 32'h1 || q_cnt[0] !== 6'd1 || q_last[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL first_edge_last: n=%0d word=%h count=%0d last=%0b required 1,00000001,1,1",
                  q_word.size(), q_word.size() ? q_word[0] : 32'hx, q_word.size() ? q_cnt[0] : 6'hx,
                  q_word.size() ? q_last[0] : 1'bx);
      end
   endtask

   task automatic test_partial();
      clear_q();
      send(15'd1, 1'b0);
      send(15'd2, 1'b0);
      send(15'd3, 1'b1);
      wait_words(1);
      n_checks++;
      if (q_word.size() != 1 || q_word[0] !== 32'h3 || q_cnt[0] !== 6'd3 || q_last[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL partial: n=%0d word=%h count=%0d last=%0b required 1,00000003,3,1",
                  q_word.size(), q_word.size() ? q_word[0] : 32'hx, q_word.size() ? q_cnt[0] : 6'hx,
                  q_word.size() ? q_last[0] : 1'bx);
      end
      n_checks++;
      if (chk_code !== 15'd3 || blocked_cnt !== 16'd35) begin
         n_fail++;
         $display("FAIL partial_hold: chk_code=%0d blocked=%0d required 3,35", chk_code, blocked_cnt);
      end
   endtask

   task automatic test_backpressure();
      int t = 0;
      int bad = 0;
      ready_force = 1'b0;
      repeat (2) @(negedge CLK);
      clear_q();
      send(15'd6, 1'b0);
      send(15'd13, 1'b1);
      while (!res_valid && t < 20) begin @(negedge CLK); t++; end
      for (int c = 0; c < 10; c++) begin
         n_checks++;
         if (res_valid !== 1'b1 || res_word !== 32'h2 || res_count !== 6'd2 || res_last !== 1'b1 || req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL backpressure_hold c%0d: valid=%0b word=%h count=%0d last=%0b ready=%0b required 1,00000002,2,1,0",
                     c, res_valid, res_word, res_count, res_last, req_ready);
         end
         @(negedge CLK);
      end
      ready_force = 1'b1;
      repeat (5) @(negedge CLK);
      n_checks++;
      if (q_word.size() != 1 || q_word[0] !== 32'h2 || res_valid !== 1'b0 || req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL backpressure_release: n=%0d valid=%0b ready=%0b required 1 word,0,1",
                  q_word.size(), res_valid, req_ready);
      end
   endtask

   task automatic test_stream();
      logic [31:0] e_word[$];
      logic [5:0]  e_cnt[$];
      logic        e_last[$];
      logic [31:0] mword = '0;
      int          mfill = 0;
      int          ones = 0;
      logic [14:0] code;
      logic        last;
      do_reset(1);
      clear_q();
      rand_ready = 1'b1;
      for (int k = 0; k < 1000; k++) begin
         code = 15'($urandom);
         last = (k == 999) || ($urandom_range(0, 39) == 0);
         repeat ($urandom_range(0, 2)) @(negedge CLK);
         send(code, last);
         mword[mfill] = ^code;
         if (^code) ones++;
         mfill++;
         if (mfill == 32 || last) begin
            e_word.push_back(mword);
            e_cnt.push_back(6'(mfill));
            e_last.push_back(last);
            mword = '0;
            mfill = 0;
         end
      end
      wait_words(e_word.size());
      rand_ready  = 1'b0;
      ready_force = 1'b1;
      repeat (4) @(negedge CLK);
      n_checks++;
      if (q_word.size() != e_word.size()) begin
         n_fail++;
         $display("FAIL stream_words: %0d words required %0d", q_word.size(), e_word.size());
      end else begin
         for (int w = 0; w < e_word.size(); w++) begin
            n_checks++;
            if (q_word[w] !== e_word[w] || q_cnt[w] !== e_cnt[w] || q_last[w] !== e_last[w]) begin
               n_fail++;
               $display("FAIL stream_word%0d: word=%h count=%0d last=%0b required %h,%0d,%0b",
                        w, q_word[w], q_cnt[w], q_last[w], e_word[w], e_cnt[w], e_last[w]);
            end
         end
      end
      n_checks++;
      if (blocked_cnt !== 16'(ones)) begin
         n_fail++;
         $display("FAIL stream_blocked: %0d required %0d", blocked_cnt, ones);
      end
   endtask

   task automatic test_saturation();
      do_reset(1);
      clear_q();
      for (int i = 0; i < 20; i++) send(15'd1, 1'b0);
      repeat (3) @(negedge CLK);
      n_checks++;
      if (blocked_cnt_s !== 4'd15 || blocked_cnt !== 16'd20) begin
         n_fail++;
         $display("FAIL saturation: cnt4=%0d cnt16=%0d required 15,20", blocked_cnt_s, blocked_cnt);
      end
      n_checks++;
      if (q_word.size() != 0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL saturation_partial: words=%0d busy=%0b required 0,1", q_word.size(), busy);
      end
   endtask

   initial begin
      test_reset();
      test_reset_mid_emit();
      test_full_word(1'b0, 16'd16);
      test_full_word(1'b1, 16'd32);
      test_first_edge_last();
      test_partial();
      test_backpressure();
      test_stream();
      test_saturation();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
